// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_pkg;
  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;
endpackage

// File: rtl/sub_cell.sv
// 1-bit borrow subtractor cell: d = a - b - bin.
module sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~(a ^ b) & bin) | (~a & b);
endmodule

// File: rtl/sub_row.sv
// N-bit ripple-borrow subtractor built from sub_cell; bout is the final borrow.
module sub_row #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         bout
);
  logic [N:0] br;

  assign br[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sub_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .bin (br[i]),
      .d   (diff[i]),
      .bout(br[i+1])
    );
  end

  assign bout = br[N];
endmodule

// File: rtl/iter_div_ctrl.sv
// Unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | W restoring steps in progress
// DONE  | result held until out_ready
module iter_div_ctrl
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(W);

  div_state_e      state;
  logic [W-1:0]    p;
  logic [W-1:0]    q;
  logic [W-1:0]    dvs;
  logic [CW-1:0]   cnt;

  logic [W:0]      s_trial;
  logic [W:0]      t_trial;
  logic            borrow;
  logic [W-1:0]    p_next;
  logic [W-1:0]    q_next;
  logic            unused_t_msb;

  assign s_trial = {p, q[W-1]};

  sub_row #(.N(W + 1)) u_sub (
    .a   (s_trial),
    .b   ({1'b0, dvs}),
    .diff(t_trial),
    .bout(borrow)
  );

  // A successful trial always fits in W bits, so the top difference bit is dropped.
  assign unused_t_msb = t_trial[W];
  assign p_next       = borrow ? s_trial[W-1:0] : t_trial[W-1:0];
  assign q_next       = {q[W-2:0], ~borrow};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      q           <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs <= divisor;
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              p     <= '0;
              q     <= dividend;
              cnt   <= CW'(W - 1);
            end
          end
        end
        CALC: begin
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            quotient    <= q_next;
            remainder   <= p_next;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
